// File: rtl/rr_arb_mux4.sv
// Round-robin arbiter over four valid/ready sources feeding a registered 4:1 selector.
// Optional per-source saturating accept counters are enabled by defining GRANT_COUNT_EN.
module rr_arb_mux4 #(
    parameter int W     = 5,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         in_valid,
    input  logic [4*W-1:0]     in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [1:0]         out_sel,
    input  logic               out_ready
`ifdef GRANT_COUNT_EN
    ,
    output logic [4*CNT_W-1:0] grant_cnt
`endif
);

    logic [1:0] ptr;
    logic [1:0] winner;
    logic       any_valid;
    logic       load;
    logic       accept;

    assign load      = ~out_valid | out_ready;
    assign any_valid = |in_valid;
    assign accept    = load & any_valid;

    // Scan from the farthest slot back toward ptr so the closest valid source wins.
    always_comb begin
        winner = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[ptr + 2'(k)]) begin
                winner = ptr + 2'(k);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ready
            // Held low while reset is asserted so no source sees a spurious grant.
            assign in_ready[gi] = rst_n & load & in_valid[gi] & (winner == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data[winner*W +: W];
            out_sel   <= winner;
            ptr       <= winner + 2'd1;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

`ifdef GRANT_COUNT_EN
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (accept && (winner == 2'(gi)) && (cnt != {CNT_W{1'b1}})) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            assign grant_cnt[gi*CNT_W +: CNT_W] = cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_rr_arb_mux4.sv
// Directed-vector bench for rr_arb_mux4: stimulus pushes expected words, a negedge monitor pops them.
// Build with GRANT_COUNT_EN defined to also exercise the saturating counters at CNT_W=2.
module tb_rr_arb_mux4;

    localparam int W = 5;
`ifdef GRANT_COUNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       in_valid;
    logic [4*W-1:0]   in_data;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [1:0]       out_sel;
    logic             out_ready;
`ifdef GRANT_COUNT_EN
    logic [4*CNT_W-1:0] grant_cnt;
`endif

    logic [W-1:0]     src_data [4];
    logic [W+1:0]     exp_q [$];
    int               n_vec = 0;
    int               n_bad = 0;

    assign in_data = {src_data[3], src_data[2], src_data[1], src_data[0]};

    always #5 clk = ~clk;

    rr_arb_mux4 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
`ifdef GRANT_COUNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL out_word: got sel=%0d data=%0h, expected no word at %0t",
                         out_sel, out_data, $time);
            end else begin
                chk("out_word", {24'd0, out_sel, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // One vector: drive after a rising edge, check in_ready mid-cycle, record the expected winner.
    task automatic vec(input logic [3:0] v, input logic rdy, input logic [3:0] exp_rdy, input int exp_sel);
        @(posedge clk);
        #1;
        in_valid  = v;
        out_ready = rdy;
        @(negedge clk);
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        if (exp_sel >= 0) begin
            exp_q.push_back({exp_sel[1:0], src_data[exp_sel[1:0]]});
        end
    endtask

    // Asynchronous reset asserted between clock edges; any held word is discarded.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 4'b0000;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {27'd0, out_data}, 32'd0);
        chk("rst_out_sel", {30'd0, out_sel}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) src_data[i] = 5'h10 + 5'(i);
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;

        // Reset with every source requesting.
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_sel", {30'd0, out_sel}, 32'd0);
        chk("reset_in_ready", {28'd0, in_ready}, 32'd0);
        in_valid = 4'b0000;
        #1;
        rst_n = 1'b1;

        // Rotation at full throughput.
        vec(4'b1111, 1'b1, 4'b0001, 0);
        vec(4'b1111, 1'b1, 4'b0010, 1);
        vec(4'b1111, 1'b1, 4'b0100, 2);
        vec(4'b1111, 1'b1, 4'b1000, 3);
        vec(4'b1111, 1'b1, 4'b0001, 0);

        // Sparse requests, wrap from 3 to 0, idle cycle keeps the pointer.
        vec(4'b0010, 1'b1, 4'b0010, 1);
        vec(4'b0100, 1'b1, 4'b0100, 2);
        vec(4'b0100, 1'b1, 4'b0100, 2);
        vec(4'b1001, 1'b1, 4'b1000, 3);
        vec(4'b1001, 1'b1, 4'b0001, 0);
        vec(4'b0000, 1'b1, 4'b0000, -1);
        vec(4'b1111, 1'b1, 4'b0010, 1);

        // Stall holding 0A, then drain and fill in the same cycle.
        src_data[2] = 5'h0A;
        vec(4'b0100, 1'b1, 4'b0100, 2);
        for (int i = 0; i < 5; i++) begin
            vec(4'b1111, 1'b0, 4'b0000, -1);
            chk("stall_out_data", {27'd0, out_data}, 32'h0A);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        vec(4'b1111, 1'b1, 4'b1000, 3);
        vec(4'b0000, 1'b1, 4'b0000, -1);

        // Async reset mid-stream: held word dropped, pointer back to 0.
        vec(4'b1111, 1'b1, 4'b0001, 0);
        async_reset();
        vec(4'b1111, 1'b1, 4'b0001, 0);
        vec(4'b0000, 1'b1, 4'b0000, -1);

`ifdef GRANT_COUNT_EN
        // Five accepts from source 1 saturate a 2-bit counter at 3.
        async_reset();
        for (int i = 0; i < 5; i++) vec(4'b0010, 1'b1, 4'b0010, 1);
        vec(4'b0000, 1'b1, 4'b0000, -1);
        chk("grant_cnt0", {30'd0, grant_cnt[0*CNT_W +: CNT_W]}, 32'd0);
        chk("grant_cnt1", {30'd0, grant_cnt[1*CNT_W +: CNT_W]}, 32'd3);
        chk("grant_cnt2", {30'd0, grant_cnt[2*CNT_W +: CNT_W]}, 32'd0);
        chk("grant_cnt3", {30'd0, grant_cnt[3*CNT_W +: CNT_W]}, 32'd0);
`endif

        @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
